seg7_count_display: RTL

Downstream display stage for the 8-bit LED counter. It takes the live 8-bit count and converts it to three BCD digits with a sequential shift-add-3 converter. It then drives a 4-digit common-anode 7-segment display by time-multiplexing. Digit 3, the leftmost, is always blank. The decimal range shown is 000–255.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/bin2bcd_seq.sv | 80 ++++++++
 rtl/seg7_count_display.sv | 76 +++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_count_display slice: converter
// state encoding, active-low segment patterns and the display digit count.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Cathode patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_pattern = SEG_0;
      4'd1:    seg_pattern = SEG_1;
      4'd2:    seg_pattern = SEG_2;
      4'd3:    seg_pattern = SEG_3;
      4'd4:    seg_pattern = SEG_4;
      4'd5:    seg_pattern = SEG_5;
      4'd6:    seg_pattern = SEG_6;
      4'd7:    seg_pattern = SEG_7;
      4'd8:    seg_pattern = SEG_8;
      4'd9:    seg_pattern = SEG_9;
      default: seg_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), free running:
// one conversion every 10 cycles, bcd_valid pulses when bcd is refreshed.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        bcd_valid
);

  conv_state_t state, state_next;

  logic [7:0]  sr;
  logic [11:0] acc;
  logic [11:0] acc_adj;
  logic [2:0]  bit_cnt;
  logic        load;
  logic        shift_en;
  logic        done;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    load     = 1'b1;
      SHIFT:   shift_en = 1'b1;
      DONE:    done     = 1'b1;
      default: load     = 1'b1;
    endcase
  end

  // Add-3 correction on every nibble >= 5 before the shift
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr        <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= done;
      if (load) begin
        sr      <= value;
        acc     <= '0;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        {acc, sr} <= {acc_adj[10:0], sr, 1'b0};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (done) bcd <= acc;
    end
  end

endmodule

// File: rtl/seg7_count_display.sv
// Count display: BCD conversion of an 8-bit value, multiplexed onto a 4-digit
// common-anode display (digit 3 blank). Optional macro SEG7_LEADING_ZERO_BLANK_EN.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          presc_tc;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_next;

  bin2bcd_seq u_conv (
    .clk       (clk),
    .clr       (clr),
    .value     (value),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  assign presc_tc = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc_tc ? '0 : presc + PW'(1);
      if (presc_tc) idx <= idx + IW'(1);
    end
  end

  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    case (idx)
      2'd0:    nib = bcd[3:0];
      2'd1:    nib = bcd[7:4];
      2'd2:    nib = bcd[11:8];
      default: blank = 1'b1;
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx == 2'd2 && bcd[11:8] == 4'd0) blank = 1'b1;
    if (idx == 2'd1 && bcd[11:4] == 8'd0) blank = 1'b1;
`endif
    seg_next = blank ? SEG_BLANK : seg_pattern(nib);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule
